ifu_axi_lite_fetch: RTL

- Instruction fetch unit directly upstream of the instruction-memory AXI4-Lite slave.
- Holds the program counter and issues word-aligned AXI4-Lite reads on the AR channel, one transaction outstanding at a time.
- Accepts read data on the R channel and buffers {pc, instruction} pairs in a small FIFO for the decode stage.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/ifu_fifo.sv | 61 ++++++
 rtl/ifu_axi_lite_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head entry is read directly from the storage array.
module ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifu_axi_lite_fetch.sv
// Instruction fetch unit: PC, single-outstanding AXI4-Lite read FSM, redirect/drop
// handling and the {pc, instr} buffer towards decode.
module ifu_axi_lite_fetch #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] PROGADDR_RESET = '0,
    parameter int unsigned           FIFO_DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready
);

    import ifu_pkg::*;

    localparam int unsigned    CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_LIM = CW'(FIFO_DEPTH);
    localparam int unsigned    EW        = ADDR_WIDTH + DATA_WIDTH;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pc, pc_n;
    logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_n;
    logic                    drop, drop_n;
    logic                    arvalid_n;
    logic [ADDR_WIDTH-1:0]   araddr_n;
    logic                    rready_n;
    logic [ADDR_WIDTH-1:0]   target;
    logic                    credit;
    logic                    push;
    logic [EW-1:0]           head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;

    assign target = i_redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    assign credit = (fifo_count + CW'(state != IDLE)) < DEPTH_LIM;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        fetch_pc_n = fetch_pc;
        drop_n     = drop;
        arvalid_n  = o_axi_arvalid;
        araddr_n   = o_axi_araddr;
        rready_n   = o_axi_rready;
        push       = 1'b0;

        if (i_redirect_valid) begin
            pc_n = target;
        end

        case (state)
            IDLE: begin
                if (credit) begin
                    arvalid_n = 1'b1;
                    araddr_n  = i_redirect_valid ? target : pc;
                    state_n   = ADDR;
                end
            end
            ADDR: begin
                if (i_redirect_valid) begin
                    drop_n = 1'b1;
                end
                if (o_axi_arvalid && i_axi_arready) begin
                    arvalid_n  = 1'b0;
                    rready_n   = 1'b1;
                    fetch_pc_n = o_axi_araddr;
                    // drop is only ever set here by a redirect in this ADDR phase,
                    // in which case pc already holds the target and must not advance
                    if (!i_redirect_valid && !drop) begin
                        pc_n = pc + ADDR_WIDTH'(INSTR_BYTES);
                    end
                    state_n = DATA;
                end
            end
            DATA: begin
                if (i_redirect_valid) begin
                    drop_n = 1'b1;
                end
                if (i_axi_rvalid && o_axi_rready) begin
                    push     = !drop && !i_redirect_valid && !fifo_full;
                    drop_n   = 1'b0;
                    rready_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= PROGADDR_RESET;
            fetch_pc      <= '0;
            drop          <= 1'b0;
            o_axi_arvalid <= 1'b0;
            o_axi_araddr  <= PROGADDR_RESET;
            o_axi_rready  <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            fetch_pc      <= fetch_pc_n;
            drop          <= drop_n;
            o_axi_arvalid <= arvalid_n;
            o_axi_araddr  <= araddr_n;
            o_axi_rready  <= rready_n;
        end
    end

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({fetch_pc, i_axi_rdata}),
        .pop       (i_instr_ready),
        .flush     (i_redirect_valid),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_instr_valid = !fifo_empty;
    assign o_instr       = head[DATA_WIDTH-1:0];
    assign o_instr_pc    = head[EW-1:DATA_WIDTH];

endmodule
